// File: rtl/load_buffer_tracker.sv
// Load buffer tracker: holds per-load metadata for loads in flight to the
// write-through data cache. Hands out buffer indices used as cache request
// IDs, then formats each returned word into a sign- or zero-extended result.
module load_buffer_tracker #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NR_ENTRIES = 2,
    parameter int unsigned TRANS_ID_W = 2,
    parameter int unsigned IDX_W      = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1,
    parameter int unsigned OFF_W      = $clog2(XLEN / 8)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  alloc_valid_i,
    output logic                  alloc_ready_o,
    input  logic [TRANS_ID_W-1:0] alloc_trans_id_i,
    input  logic [OFF_W-1:0]      alloc_offset_i,
    input  logic [1:0]            alloc_size_i,
    input  logic                  alloc_signed_i,
    output logic [IDX_W-1:0]      alloc_idx_o,
    input  logic                  rsp_valid_i,
    input  logic [IDX_W-1:0]      rsp_idx_i,
    input  logic [XLEN-1:0]       rsp_data_i,
    output logic                  res_valid_o,
    output logic [TRANS_ID_W-1:0] res_trans_id_o,
    output logic [XLEN-1:0]       res_data_o,
    output logic [IDX_W:0]        count_o,
    output logic                  empty_o,
    output logic                  rsp_err_o
);

    logic [NR_ENTRIES-1:0] occupied_q;
    logic [NR_ENTRIES-1:0] killed_q;
    logic [NR_ENTRIES-1:0] signed_q;
    logic [TRANS_ID_W-1:0] trans_id_q [NR_ENTRIES];
    logic [OFF_W-1:0]      offset_q   [NR_ENTRIES];
    logic [1:0]            size_q     [NR_ENTRIES];
    logic [IDX_W:0]        count_q;

    logic [IDX_W-1:0] free_idx;
    logic             alloc_fire;
    logic             rsp_idx_ok;
    logic             rsp_hit;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  keep_mask;
    logic             sign_bit;
    logic [XLEN-1:0]  ext_data;

    // With a single entry the index port is wider than the array; reject index 1.
    if (NR_ENTRIES == 1) begin : g_one_entry
        assign rsp_idx_ok = (rsp_idx_i == '0);
    end else begin : g_multi_entry
        assign rsp_idx_ok = 1'b1;
    end

    // Lowest-numbered free entry (scan from the top so the lowest wins).
    always_comb begin
        free_idx = '0;
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            if (!occupied_q[NR_ENTRIES-1-i]) begin
                free_idx = IDX_W'(NR_ENTRIES - 1 - i);
            end
        end
    end

    assign alloc_ready_o = !(&occupied_q) && !flush_i;
    assign alloc_idx_o   = free_idx;
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;
    assign rsp_hit       = rsp_valid_i && rsp_idx_ok && occupied_q[rsp_idx_i];

    // Shift the requested bytes down, keep the access width, then extend.
    always_comb begin
        shifted   = rsp_data_i >> {offset_q[rsp_idx_i], 3'b000};
        keep_mask = XLEN'(32'hFFFF_FFFF);
        sign_bit  = shifted[31];
        case (size_q[rsp_idx_i])
            2'd0: begin
                keep_mask = XLEN'(8'hFF);
                sign_bit  = shifted[7];
            end
            2'd1: begin
                keep_mask = XLEN'(16'hFFFF);
                sign_bit  = shifted[15];
            end
            2'd2: begin
                keep_mask = XLEN'(32'hFFFF_FFFF);
                sign_bit  = shifted[31];
            end
            default: begin
                if (XLEN == 64) begin
                    keep_mask = '1;
                    sign_bit  = shifted[XLEN-1];
                end
            end
        endcase
        ext_data = (shifted & keep_mask) |
                   ((signed_q[rsp_idx_i] && sign_bit) ? ~keep_mask : '0);
    end

    // Entry occupancy and kill flags; allocation and response never share an index.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occupied_q <= '0;
            killed_q   <= '0;
        end else begin
            if (flush_i) begin
                killed_q <= killed_q | occupied_q;
            end
            if (alloc_fire) begin
                occupied_q[free_idx] <= 1'b1;
                killed_q[free_idx]   <= 1'b0;
            end
            if (rsp_hit) begin
                occupied_q[rsp_idx_i] <= 1'b0;
            end
        end
    end

    // Per-entry load attributes captured on allocation.
    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            trans_id_q[free_idx] <= alloc_trans_id_i;
            offset_q[free_idx]   <= alloc_offset_i;
            size_q[free_idx]     <= alloc_size_i;
            signed_q[free_idx]   <= alloc_signed_i;
        end
    end

    // Occupied-entry count: +1 per allocation, -1 per accepted response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            case ({alloc_fire, rsp_hit})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Registered result; killed entries and flush-cycle responses are dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_valid_o    <= 1'b0;
            res_trans_id_o <= '0;
            res_data_o     <= '0;
        end else begin
            res_valid_o <= rsp_hit && !killed_q[rsp_idx_i] && !flush_i;
            if (rsp_hit && !killed_q[rsp_idx_i] && !flush_i) begin
                res_trans_id_o <= trans_id_q[rsp_idx_i];
                res_data_o     <= ext_data;
            end
        end
    end

    // Sticky flag for responses that match no occupied entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_err_o <= 1'b0;
        end else if (rsp_valid_i && !rsp_hit) begin
            rsp_err_o <= 1'b1;
        end
    end

    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule
